// File: rtl/fpu_div_pkg.sv
// Shared types and sizing for the FPU mantissa divide path.
package fpu_div_pkg;

  localparam int unsigned N     = 24;
  localparam int unsigned FRAC  = 26;
  localparam int unsigned Q_W   = N + FRAC;
  localparam int unsigned CNT_W = $clog2(Q_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// subtract the divisor when it fits, report the resulting quotient bit.
module div_step #(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0] p_in,
  input  logic         bit_in,
  input  logic [N-1:0] b,
  output logic [N-1:0] p_out,
  output logic         q_bit
);

  logic [N:0] sh;

  // p_in < b on entry, so the shifted value is < 2b and the difference fits N bits
  always_comb begin
    sh    = {p_in, bit_in};
    q_bit = (sh >= {1'b0, b});
    p_out = q_bit ? (sh[N-1:0] - b) : sh[N-1:0];
  end

endmodule

// File: rtl/mant_div_seq.sv
// Sequential radix-2 restoring mantissa divider: Q = floor((A << FRAC) / B),
// one quotient bit per clock. Optional macro MANT_DIV_EARLY_EXIT_EN ends the
// iteration once the partial remainder and all remaining dividend bits are zero.
module mant_div_seq #(
  parameter int unsigned N    = fpu_div_pkg::N,
  parameter int unsigned FRAC = fpu_div_pkg::FRAC
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [N-1:0]        i_A,
  input  logic [N-1:0]        i_B,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N+FRAC-1:0]   o_Q,
  output logic [N-1:0]        o_R,
  output logic                o_sticky,
  output logic                o_dz
);

  import fpu_div_pkg::*;

  localparam int unsigned QW = N + FRAC;
  localparam int unsigned CW = $clog2(QW);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;      // remaining dividend bits, MSB next; FRAC zeros follow implicitly
  logic [N-1:0]  b_reg;
  logic [N-1:0]  p_reg;    // partial remainder kept at N bits: it is always < B between steps
  logic [QW-1:0] q_reg;

  logic [N-1:0]  p_nxt;
  logic          q_bit;
  logic [QW-1:0] q_nxt;
  logic [QW-1:0] q_fin;
  logic          last_step;
  logic          finish;

  div_step #(.N(N)) u_step (
    .p_in   (p_reg),
    .bit_in (dvd[N-1]),
    .b      (b_reg),
    .p_out  (p_nxt),
    .q_bit  (q_bit)
  );

  assign o_ready = (state == IDLE);

  // Next quotient and termination decision for the current step
  always_comb begin
    q_nxt     = {q_reg[QW-2:0], q_bit};
    last_step = (cnt == CW'(QW - 1));
`ifdef MANT_DIV_EARLY_EXIT_EN
    finish    = last_step || ((p_nxt == '0) && (dvd[N-2:0] == '0));
    q_fin     = q_nxt << (CW'(QW - 1) - cnt);
`else
    finish    = last_step;
    q_fin     = q_nxt;
`endif
  end

  // Control FSM, iteration registers and registered result outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      q_reg    <= '0;
      o_valid  <= 1'b0;
      o_Q      <= '0;
      o_R      <= '0;
      o_sticky <= 1'b0;
      o_dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_B == '0) begin
              o_Q      <= '1;
              o_R      <= i_A;
              o_sticky <= |i_A;
              o_dz     <= 1'b1;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              dvd   <= i_A;
              b_reg <= i_B;
              p_reg <= '0;
              q_reg <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          dvd   <= {dvd[N-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (finish) begin
            o_Q      <= q_fin;
            o_R      <= p_nxt;
            o_sticky <= |p_nxt;
            o_dz     <= 1'b0;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq (directed vectors plus random model check).
module tb_mant_div_seq;

  localparam int unsigned N    = 24;
  localparam int unsigned FRAC = 26;
  localparam int unsigned QW   = N + FRAC;
`ifdef MANT_DIV_EARLY_EXIT_EN
  localparam int EXACT_LAT = 25;
  localparam int ZERO_LAT  = 1;
`else
  localparam int EXACT_LAT = 50;
  localparam int ZERO_LAT  = 50;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [N-1:0]  i_A = '0;
  logic [N-1:0]  i_B = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [QW-1:0] o_Q;
  logic [N-1:0]  o_R;
  logic          o_sticky;
  logic          o_dz;

  int checks = 0;
  int errors = 0;

  mant_div_seq #(.N(N), .FRAC(FRAC)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_A      (i_A),
    .i_B      (i_B),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_Q      (o_Q),
    .o_R      (o_R),
    .o_sticky (o_sticky),
    .o_dz     (o_dz)
  );

  always #5 clk = ~clk;

  // Present operands for one edge; scramble them afterwards (must be ignored)
  task automatic do_accept(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    i_A = a; i_B = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_A = N'($urandom); i_B = N'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({o_valid, o_ready, o_sticky, o_dz} !== 4'b0100) begin
      errors++; $display("FAIL reset_flags: got %b want 0100", {o_valid, o_ready, o_sticky, o_dz});
    end
    checks++;
    if (o_Q !== '0 || o_R !== '0) begin
      errors++; $display("FAIL reset_data: got Q=%h R=%h want 0/0", o_Q, o_R);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    int lat;
    do_accept(24'hC00000, 24'h800000);
    wait_valid(lat);
    checks++;
    if (lat !== EXACT_LAT) begin errors++; $display("FAIL exact_latency: got %0d want %0d", lat, EXACT_LAT); end
    checks++;
    if (o_Q !== 50'h0000006000000) begin errors++; $display("FAIL exact_Q: got %h want 0000006000000", o_Q); end
    checks++;
    if ({o_R, o_sticky, o_dz} !== {24'h0, 2'b00}) begin
      errors++; $display("FAIL exact_R: got R=%h s=%b dz=%b want 0/0/0", o_R, o_sticky, o_dz);
    end
    handshake();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL exact_handshake: got v/r=%b want 01", {o_valid, o_ready}); end
    checks++;
    if (o_Q !== 50'h0000006000000) begin errors++; $display("FAIL exact_Q_kept: got %h want 0000006000000", o_Q); end
  endtask

  task automatic test_inexact();
    int lat;
    do_accept(24'h000001, 24'h000003);
    wait_valid(lat);
    checks++;
    if (o_Q !== 50'h0000001555555) begin errors++; $display("FAIL inexact_Q: got %h want 0000001555555", o_Q); end
    checks++;
    if ({o_R, o_sticky, o_dz} !== {24'h000001, 2'b10}) begin
      errors++; $display("FAIL inexact_R: got R=%h s=%b dz=%b want 1/1/0", o_R, o_sticky, o_dz);
    end
    handshake();
  endtask

  task automatic test_div_zero();
    int lat;
    do_accept(24'h000005, 24'h000000);
    wait_valid(lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d want 0", lat); end
    checks++;
    if (o_Q !== {QW{1'b1}}) begin errors++; $display("FAIL dz_Q: got %h want all ones", o_Q); end
    checks++;
    if ({o_R, o_sticky, o_dz} !== {24'h000005, 2'b11}) begin
      errors++; $display("FAIL dz_R: got R=%h s=%b dz=%b want 5/1/1", o_R, o_sticky, o_dz);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    do_accept(24'hFFFFFF, 24'h000001);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      i_valid = i[0];
      i_A = 24'h000007; i_B = 24'h000002;
      @(posedge clk); #1;
      checks++;
      if ({o_valid, o_ready} !== 2'b10 || o_Q !== 50'h3FFFFFC000000 || o_R !== '0) begin
        errors++;
        $display("FAIL hold_%0d: got v/r=%b Q=%h R=%h want 10 3FFFFFC000000 0", i, {o_valid, o_ready}, o_Q, o_R);
      end
    end
    i_valid = 1'b0;
    handshake();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got v/r=%b want 01", {o_valid, o_ready}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_accept(24'hC00000, 24'h800000);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_ready} !== 2'b01 || o_Q !== '0) begin
      errors++; $display("FAIL midreset_state: got v/r=%b Q=%h want 01 0", {o_valid, o_ready}, o_Q);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++; $display("FAIL midreset_abandon: got v/r=%b want 01", {o_valid, o_ready});
    end
    do_accept(24'h000001, 24'h000003);
    wait_valid(lat);
    checks++;
    if (o_Q !== 50'h0000001555555 || o_R !== 24'h000001) begin
      errors++; $display("FAIL midreset_next: got Q=%h R=%h want 0000001555555 1", o_Q, o_R);
    end
    handshake();
  endtask

  task automatic test_zero_dividend();
    int lat;
    do_accept(24'h000000, 24'h123456);
    wait_valid(lat);
    checks++;
    if (lat !== ZERO_LAT) begin errors++; $display("FAIL zeroA_latency: got %0d want %0d", lat, ZERO_LAT); end
    checks++;
    if (o_Q !== '0 || {o_R, o_sticky, o_dz} !== {24'h0, 2'b00}) begin
      errors++; $display("FAIL zeroA_result: got Q=%h R=%h s=%b dz=%b want 0", o_Q, o_R, o_sticky, o_dz);
    end
    handshake();
  endtask

  task automatic test_max_operands();
    int lat;
    do_accept(24'hFFFFFF, 24'hFFFFFF);
    wait_valid(lat);
    checks++;
    if (o_Q !== 50'h0000004000000 || o_R !== '0) begin
      errors++; $display("FAIL max_equal: got Q=%h R=%h want 0000004000000 0", o_Q, o_R);
    end
    handshake();
  endtask

  // Back-to-back random operations against a 64-bit arithmetic reference
  task automatic test_random();
    int lat;
    logic [N-1:0]  a, b;
    longint unsigned d, eq, er;
    for (int k = 0; k < 1000; k++) begin
      a = N'($urandom);
      b = (k % 97 == 5) ? '0 : N'($urandom);
      if (k % 13 == 0) b = N'($urandom_range(1, 255));
      if (b == '0) begin
        eq = {14'h0, {QW{1'b1}}};
        er = longint'(a);
      end else begin
        d  = longint'(a) << FRAC;
        eq = d / longint'(b);
        er = d % longint'(b);
      end
      do_accept(a, b);
      wait_valid(lat);
      checks++;
      if (lat >= 200 || o_Q !== eq[QW-1:0] || o_R !== er[N-1:0] || o_sticky !== (er != 0) || o_dz !== (b == '0)) begin
        errors++;
        $display("FAIL rand_%0d: A=%h B=%h got Q=%h R=%h s=%b dz=%b want Q=%h R=%h", k, a, b,
                 o_Q, o_R, o_sticky, o_dz, eq[QW-1:0], er[N-1:0]);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_inexact();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_zero_dividend();
    test_max_operands();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
